// File: rtl/rv_multicycle_ctrl.sv
// Main control FSM of the multicycle RV32I core: sequences fetch/decode/execute/memory/writeback
// and drives Alu control, operand selects, memory requests and register-file writes.
module rv_multicycle_ctrl #(
  parameter int unsigned RESET_STATE = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7_5_i,
  input  logic       alu_zero_i,
  input  logic       alu_lsb_i,
  input  logic       mem_ready_i,
  output logic [3:0] alu_control_o,
  output logic [1:0] alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [2:0] imm_src_o,
  output logic [1:0] result_src_o,
  output logic       adr_src_o,
  output logic       mem_req_o,
  output logic       mem_we_o,
  output logic       ir_write_o,
  output logic       pc_write_o,
  output logic       reg_write_o,
  output logic       illegal_o
);

  localparam int unsigned StateW = 4;

  typedef enum logic [StateW-1:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXEC_R, S_EXEC_I,
    S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_JALR_WB, S_LUI, S_AUIPC, S_TRAP
  } state_e;

  localparam state_e ResetSt = state_e'(StateW'(RESET_STATE));

  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR = 4'd3,
                         ALU_SLT = 4'd4, ALU_XOR = 4'd5, ALU_SLL = 4'd6, ALU_SRL = 4'd7,
                         ALU_SRA = 4'd8, ALU_SLTU = 4'd9;
  localparam logic [1:0] SRCA_PC = 2'd0, SRCA_OLDPC = 2'd1, SRCA_RS1 = 2'd2;
  localparam logic [1:0] SRCB_RS2 = 2'd0, SRCB_IMM = 2'd1, SRCB_FOUR = 2'd2;
  localparam logic [2:0] IMM_I = 3'd0, IMM_S = 3'd1, IMM_B = 3'd2, IMM_U = 3'd4;
  localparam logic [1:0] RES_ALUOUT = 2'd0, RES_MEM = 2'd1, RES_ALU = 2'd2;
  localparam logic [6:0] OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011, OP_R = 7'b0110011,
                         OP_I = 7'b0010011, OP_BRANCH = 7'b1100011, OP_JAL = 7'b1101111,
                         OP_JALR = 7'b1100111, OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111;

  state_e state_q, state_d;
  logic   illegal_q, illegal_d;
  logic   take;

  // funct3 -> Alu op; only register-register ops use funct7[5] to select SUB
  function automatic logic [3:0] funct_alu(input logic [2:0] f3, input logic f7, input logic is_r);
    case (f3)
      3'b000:  funct_alu = (is_r && f7) ? ALU_SUB : ALU_ADD;
      3'b001:  funct_alu = ALU_SLL;
      3'b010:  funct_alu = ALU_SLT;
      3'b011:  funct_alu = ALU_SLTU;
      3'b100:  funct_alu = ALU_XOR;
      3'b101:  funct_alu = f7 ? ALU_SRA : ALU_SRL;
      3'b110:  funct_alu = ALU_OR;
      default: funct_alu = ALU_AND;
    endcase
  endfunction

  always_comb begin
    state_d       = state_q;
    take          = 1'b0;
    alu_control_o = ALU_ADD;
    alu_src_a_o   = SRCA_PC;
    alu_src_b_o   = SRCB_RS2;
    imm_src_o     = IMM_I;
    result_src_o  = RES_ALUOUT;
    adr_src_o     = 1'b0;
    mem_req_o     = 1'b0;
    mem_we_o      = 1'b0;
    ir_write_o    = 1'b0;
    pc_write_o    = 1'b0;
    reg_write_o   = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_req_o    = 1'b1;
        alu_src_b_o  = SRCB_FOUR;
        result_src_o = RES_ALU;
        if (mem_ready_i) begin
          ir_write_o = 1'b1;
          pc_write_o = 1'b1;
          state_d    = S_DECODE;
        end
      end
      S_DECODE: begin
        // Branch target is precomputed here into alu_out
        alu_src_a_o = SRCA_OLDPC;
        alu_src_b_o = SRCB_IMM;
        imm_src_o   = IMM_B;
        case (opcode_i)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_R:              state_d = S_EXEC_R;
          OP_I:              state_d = S_EXEC_I;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR;
          OP_LUI:            state_d = S_LUI;
          OP_AUIPC:          state_d = S_AUIPC;
          default:           state_d = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        alu_src_a_o = SRCA_RS1;
        alu_src_b_o = SRCB_IMM;
        imm_src_o   = opcode_i[5] ? IMM_S : IMM_I;
        state_d     = opcode_i[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        mem_req_o = 1'b1;
        adr_src_o = 1'b1;
        if (mem_ready_i) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_src_o = RES_MEM;
        reg_write_o  = 1'b1;
        state_d      = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_req_o = 1'b1;
        mem_we_o  = 1'b1;
        adr_src_o = 1'b1;
        if (mem_ready_i) state_d = S_FETCH;
      end
      S_EXEC_R: begin
        alu_src_a_o   = SRCA_RS1;
        alu_control_o = funct_alu(funct3_i, funct7_5_i, 1'b1);
        state_d       = S_ALUWB;
      end
      S_EXEC_I: begin
        alu_src_a_o   = SRCA_RS1;
        alu_src_b_o   = SRCB_IMM;
        alu_control_o = funct_alu(funct3_i, funct7_5_i, 1'b0);
        state_d       = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_o = 1'b1;
        state_d     = S_FETCH;
      end
      S_BRANCH: begin
        // funct3[0] inverts the sense of the condition (NE/GE/GEU)
        alu_src_a_o = SRCA_RS1;
        state_d     = S_FETCH;
        case (funct3_i)
          3'b000, 3'b001: begin alu_control_o = ALU_SUB;  take = alu_zero_i ^ funct3_i[0]; end
          3'b100, 3'b101: begin alu_control_o = ALU_SLT;  take = alu_lsb_i ^ funct3_i[0]; end
          3'b110, 3'b111: begin alu_control_o = ALU_SLTU; take = alu_lsb_i ^ funct3_i[0]; end
          default:        state_d = S_TRAP;
        endcase
        pc_write_o = take;
      end
      S_JAL: begin
        alu_src_a_o = SRCA_OLDPC;
        alu_src_b_o = SRCB_FOUR;
        pc_write_o  = 1'b1;
        state_d     = S_ALUWB;
      end
      S_JALR: begin
        alu_src_a_o = SRCA_RS1;
        alu_src_b_o = SRCB_IMM;
        state_d     = S_JALR_WB;
      end
      S_JALR_WB: begin
        // pc takes the target from alu_out while the Alu forms the link old_pc+4
        alu_src_a_o = SRCA_OLDPC;
        alu_src_b_o = SRCB_FOUR;
        pc_write_o  = 1'b1;
        state_d     = S_ALUWB;
      end
      S_LUI: begin
        alu_src_a_o = SRCA_RS1;
        alu_src_b_o = SRCB_IMM;
        imm_src_o   = IMM_U;
        state_d     = S_ALUWB;
      end
      S_AUIPC: begin
        alu_src_a_o = SRCA_OLDPC;
        alu_src_b_o = SRCB_IMM;
        imm_src_o   = IMM_U;
        state_d     = S_ALUWB;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = ResetSt;
    endcase

    // Reset silences every strobe immediately, aborting any pending request
    if (!rst) begin
      alu_control_o = ALU_ADD;
      alu_src_a_o   = '0;
      alu_src_b_o   = '0;
      imm_src_o     = '0;
      result_src_o  = '0;
      adr_src_o     = 1'b0;
      mem_req_o     = 1'b0;
      mem_we_o      = 1'b0;
      ir_write_o    = 1'b0;
      pc_write_o    = 1'b0;
      reg_write_o   = 1'b0;
    end

    illegal_d = illegal_q | (state_d == S_TRAP);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ResetSt;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  assign illegal_o = illegal_q;

endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// Randomized bench for rv_multicycle_ctrl: a per-instruction phase plan built from the
// instruction semantics is checked cycle by cycle against the control outputs.
module tb_rv_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [6:0] opcode = '0;
  logic [2:0] funct3 = '0;
  logic       funct7_5 = 1'b0;
  logic       alu_zero = 1'b0;
  logic       alu_lsb = 1'b0;
  logic       mem_ready = 1'b0;
  logic [3:0] alu_control;
  logic [1:0] alu_src_a, alu_src_b, result_src;
  logic [2:0] imm_src;
  logic       adr_src, mem_req, mem_we, ir_write, pc_write, reg_write, illegal;

  always #5 clk = ~clk;

  rv_multicycle_ctrl #(.RESET_STATE(0)) dut (
    .clk(clk), .rst(rst), .opcode_i(opcode), .funct3_i(funct3), .funct7_5_i(funct7_5),
    .alu_zero_i(alu_zero), .alu_lsb_i(alu_lsb), .mem_ready_i(mem_ready),
    .alu_control_o(alu_control), .alu_src_a_o(alu_src_a), .alu_src_b_o(alu_src_b),
    .imm_src_o(imm_src), .result_src_o(result_src), .adr_src_o(adr_src),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .ir_write_o(ir_write), .pc_write_o(pc_write),
    .reg_write_o(reg_write), .illegal_o(illegal)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail = 0;
  int force_z = -1;
  int force_l = -1;

  localparam logic [3:0] A_ADD = 4'd0, A_SUB = 4'd1, A_SLT = 4'd4, A_SRA = 4'd8, A_SLTU = 4'd9;

  typedef enum logic [3:0] {
    T_FETCH, T_DECODE, T_MEMADR, T_MEMREAD, T_MEMWB, T_MEMWRITE, T_EXEC_R, T_EXEC_I,
    T_ALUWB, T_BRANCH, T_JAL, T_JALR, T_JALR_WB, T_LUI, T_AUIPC, T_TRAP
  } tag_e;

  typedef struct packed {
    logic [3:0] alu; logic [1:0] sa; logic [1:0] sb; logic [2:0] imm; logic [1:0] rs;
    logic adr; logic req; logic we; logic irw; logic pcw; logic rw; logic ill;
  } vec_t;

  typedef struct packed { tag_e tag; vec_t v; logic mem_wait; logic branch; } phase_t;

  phase_t plan[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %05h expected %05h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] dut_vec();
    return 32'({alu_control, alu_src_a, alu_src_b, imm_src, result_src, adr_src, mem_req,
                mem_we, ir_write, pc_write, reg_write, illegal});
  endfunction

  function automatic void push(input tag_e t, input logic [3:0] alu, input logic [1:0] sa,
                               input logic [1:0] sb, input logic [2:0] imm, input logic [1:0] rs,
                               input logic adr, input logic req, input logic we, input logic pcw,
                               input logic rw, input logic wt, input logic br);
    phase_t p;
    p.tag = t;
    p.v = '{alu: alu, sa: sa, sb: sb, imm: imm, rs: rs, adr: adr, req: req, we: we,
            irw: (t == T_FETCH), pcw: pcw, rw: rw, ill: (t == T_TRAP)};
    p.mem_wait = wt;
    p.branch = br;
    plan.push_back(p);
  endfunction

  // Alu op an arithmetic instruction should request, from the ISA operation table
  function automatic logic [3:0] ref_alu(input logic [2:0] f3, input logic f7, input logic is_r);
    logic [31:0] tbl;
    tbl = {4'd2, 4'd3, 4'd7, 4'd5, 4'd9, 4'd4, 4'd6, 4'd0};
    if (f3 == 3'd0 && f7 && is_r) return A_SUB;
    if (f3 == 3'd5 && f7) return A_SRA;
    return tbl[f3*4 +: 4];
  endfunction

  function automatic logic ref_take(input logic [2:0] f3, input logic z, input logic lsb);
    case (f3)
      3'd0: return z;        // BEQ
      3'd1: return !z;       // BNE
      3'd4: return lsb;      // BLT
      3'd5: return !lsb;     // BGE
      3'd6: return lsb;      // BLTU
      3'd7: return !lsb;     // BGEU
      default: return 1'b0;
    endcase
  endfunction

  // Builds the expected phase plan; returns 1 when the instruction ends in TRAP
  function automatic bit build(input logic [31:0] instr);
    logic [6:0] op;
    logic [2:0] f3;
    logic f7;
    bit trap;
    op = instr[6:0]; f3 = instr[14:12]; f7 = instr[30];
    trap = 1'b0;
    plan.delete();
    push(T_FETCH,  A_ADD, 2'd0, 2'd2, 3'd0, 2'd2, 0, 1, 0, 1, 0, 1, 0);
    push(T_DECODE, A_ADD, 2'd1, 2'd1, 3'd2, 2'd0, 0, 0, 0, 0, 0, 0, 0);
    case (op)
      7'b0000011: begin
        push(T_MEMADR,  A_ADD, 2'd2, 2'd1, 3'd0, 2'd0, 0, 0, 0, 0, 0, 0, 0);
        push(T_MEMREAD, A_ADD, 2'd0, 2'd0, 3'd0, 2'd0, 1, 1, 0, 0, 0, 1, 0);
        push(T_MEMWB,   A_ADD, 2'd0, 2'd0, 3'd0, 2'd1, 0, 0, 0, 0, 1, 0, 0);
      end
      7'b0100011: begin
        push(T_MEMADR,   A_ADD, 2'd2, 2'd1, 3'd1, 2'd0, 0, 0, 0, 0, 0, 0, 0);
        push(T_MEMWRITE, A_ADD, 2'd0, 2'd0, 3'd0, 2'd0, 1, 1, 1, 0, 0, 1, 0);
      end
      7'b0110011: push(T_EXEC_R, ref_alu(f3, f7, 1'b1), 2'd2, 2'd0, 3'd0, 2'd0, 0, 0, 0, 0, 0, 0, 0);
      7'b0010011: push(T_EXEC_I, ref_alu(f3, f7, 1'b0), 2'd2, 2'd1, 3'd0, 2'd0, 0, 0, 0, 0, 0, 0, 0);
      7'b1100011: begin
        if (f3 == 3'd2 || f3 == 3'd3) begin
          push(T_BRANCH, A_ADD, 2'd2, 2'd0, 3'd0, 2'd0, 0, 0, 0, 0, 0, 0, 0);
          trap = 1'b1;
        end else begin
          push(T_BRANCH, (f3[2:1] == 2'b00) ? A_SUB : (f3[1] ? A_SLTU : A_SLT),
               2'd2, 2'd0, 3'd0, 2'd0, 0, 0, 0, 0, 0, 0, 1);
        end
      end
      7'b1101111: push(T_JAL, A_ADD, 2'd1, 2'd2, 3'd0, 2'd0, 0, 0, 0, 1, 0, 0, 0);
      7'b1100111: begin
        push(T_JALR,    A_ADD, 2'd2, 2'd1, 3'd0, 2'd0, 0, 0, 0, 0, 0, 0, 0);
        push(T_JALR_WB, A_ADD, 2'd1, 2'd2, 3'd0, 2'd0, 0, 0, 0, 1, 0, 0, 0);
      end
      7'b0110111: push(T_LUI,   A_ADD, 2'd2, 2'd1, 3'd4, 2'd0, 0, 0, 0, 0, 0, 0, 0);
      7'b0010111: push(T_AUIPC, A_ADD, 2'd1, 2'd1, 3'd4, 2'd0, 0, 0, 0, 0, 0, 0, 0);
      default: trap = 1'b1;
    endcase
    if (trap) begin
      for (int i = 0; i < 10; i++)
        push(T_TRAP, A_ADD, 2'd0, 2'd0, 3'd0, 2'd0, 0, 0, 0, 0, 0, 0, 0);
    end else if (op inside {7'b0110011, 7'b0010011, 7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111}) begin
      push(T_ALUWB, A_ADD, 2'd0, 2'd0, 3'd0, 2'd0, 0, 0, 0, 0, 1, 0, 0);
    end
    return trap;
  endfunction

  // stall >= 0: mem_ready held low that many cycles per wait phase; < 0: random readiness
  task automatic run_plan(input int stall);
    phase_t p;
    int waits;
    bit done;
    logic rdy, z, l;
    vec_t e;
    while (plan.size() > 0) begin
      p = plan.pop_front();
      waits = 0;
      done = 1'b0;
      while (!done) begin
        if (stall >= 0) rdy = (waits >= stall);
        else rdy = (waits >= 6) || ($urandom_range(0, 3) != 0);
        z = (force_z >= 0) ? 1'(force_z) : 1'($urandom);
        l = (force_l >= 0) ? 1'(force_l) : 1'($urandom);
        mem_ready = rdy; alu_zero = z; alu_lsb = l;
        @(negedge clk);
        e = p.v;
        if (p.mem_wait && !rdy) begin e.irw = 1'b0; e.pcw = 1'b0; end
        if (p.branch) e.pcw = ref_take(funct3, z, l);
        check_eq(p.tag.name(), dut_vec(), 32'(e));
        @(posedge clk); #1;
        if (!p.mem_wait || rdy) done = 1'b1;
        else waits++;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    check_eq("reset_outputs", dut_vec(), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic run_instr(input logic [31:0] instr, input int stall);
    bit trapped;
    opcode = instr[6:0]; funct3 = instr[14:12]; funct7_5 = instr[30];
    trapped = build(instr);
    run_plan(stall);
    if (trapped) do_reset();
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 19))
      0, 1:    w[6:0] = 7'b0000011;
      2, 3:    w[6:0] = 7'b0100011;
      4, 5, 6: w[6:0] = 7'b0110011;
      7, 8, 9: w[6:0] = 7'b0010011;
      10, 11:  w[6:0] = 7'b1100011;
      12:      w[6:0] = 7'b1101111;
      13:      w[6:0] = 7'b1100111;
      14:      w[6:0] = 7'b0110111;
      15:      w[6:0] = 7'b0010111;
      16:      w[6:0] = 7'b1110011;
      17:      w[6:0] = 7'b0001111;
      default: w[6:0] = 7'b0110011;
    endcase
    return w;
  endfunction

  initial begin
    vec_t e;
    #1;
    check_eq("reset_initial", dut_vec(), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    run_instr(32'h002081B3, 0);   // ADD
    run_instr(32'h402081B3, 0);   // SUB
    run_instr(32'h4050D093, 0);   // SRAI
    run_instr(32'h40008093, 0);   // ADDI, imm bit30 set
    force_z = 0; run_instr(32'h00209463, 0);   // BNE taken
    force_z = 1; run_instr(32'h00209463, 0);   // BNE not taken
    force_z = -1;
    force_l = 1; run_instr(32'h0020C463, 0);   // BLT taken
    force_l = -1;
    run_instr(32'h0000A183, 3);   // LW with stalls in FETCH and MEMREAD
    run_instr(32'h0020A023, 2);   // SW with stalls
    run_instr(32'h008000EF, 0);   // JAL
    run_instr(32'h000080E7, 0);   // JALR
    run_instr(32'h123450B7, 0);   // LUI
    run_instr(32'h12345097, 0);   // AUIPC

    // Reset asserted while a load is waiting in MEMREAD
    opcode = 7'b0000011; funct3 = 3'b010; funct7_5 = 1'b0;
    void'(build(32'h0000A183));
    while (plan.size() > 3) void'(plan.pop_back());
    run_plan(0);
    mem_ready = 1'b0;
    @(negedge clk);
    e = '0; e.adr = 1'b1; e.req = 1'b1;
    check_eq("memread_wait", dut_vec(), 32'(e));
    rst = 1'b0;
    #1;
    check_eq("reset_mid_memread", dut_vec(), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    run_instr(32'h002081B3, 2);   // resumes at FETCH with illegal clear

    for (int i = 0; i < 150; i++) run_instr(rand_instr(), -1);

    run_instr(32'h0000007F, 0);   // unsupported opcode
    run_instr(32'h0020A063, 0);   // branch funct3 010
    run_instr(32'h0000A183, -1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
